// File: rtl/vga_2bit.sv
// vga_2bit: 640x480@60 Hz VGA timing generator with colour-bar / gradient-XOR test patterns, 2 bits per channel.
// Optional macro VGA_BORDER_EN: white 1-pixel border around the visible area (default build: no border).
module vga_2bit #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       SEL,
  output logic       Hs,
  output logic       Vs,
  output logic       Blank,
  output logic [1:0] R,
  output logic [1:0] G,
  output logic [1:0] B
);

  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] BAR_W    = 11'(H_ACTIVE / 8);

  // Bar index from threshold comparisons so no divider is needed.
  function automatic logic [2:0] bar_index(input logic [10:0] x);
    logic [2:0] k;
    k = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 11'(BAR_W * i)) k = 3'(i);
    end
    return k;
  endfunction

  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        sel_q, sel_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_q, blank_d;
  logic [5:0]  rgb_q, rgb_d;
  logic [2:0]  bar_k_s;
  logic [1:0]  grad_r_s, grad_g_s;
  logic        on_border_s;

  // Raster counters; the pattern select is only sampled at frame start so a switch never tears.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = 11'd0;
      if (vcnt_q == V_LAST) vcnt_d = 11'd0;
      else                  vcnt_d = vcnt_q + 11'd1;
    end else begin
      hcnt_d = hcnt_q + 11'd1;
    end
    if ((hcnt_q == 11'd0) && (vcnt_q == 11'd0)) sel_d = SEL;
    else                                        sel_d = sel_q;
  end

  // Sync, blanking and pixel colour for the current counter position.
  always_comb begin
    bar_k_s  = bar_index(hcnt_q);
    grad_r_s = hcnt_q[7:6];
    grad_g_s = vcnt_q[7:6];
`ifdef VGA_BORDER_EN
    on_border_s = (hcnt_q == 11'd0) || (hcnt_q == H_VIS - 11'd1) ||
                  (vcnt_q == 11'd0) || (vcnt_q == V_VIS - 11'd1);
`else
    on_border_s = 1'b0;
`endif
    hs_d    = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
    vs_d    = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
    blank_d = (hcnt_q >= H_VIS) || (vcnt_q >= V_VIS);
    if (blank_d) begin
      rgb_d = 6'b000000;
    end else if (on_border_s) begin
      rgb_d = 6'b111111;
    end else if (!sel_d) begin
      rgb_d = {bar_k_s[2], bar_k_s[2], bar_k_s[1], bar_k_s[1], bar_k_s[0], bar_k_s[0]};
    end else begin
      rgb_d = {grad_r_s, grad_g_s, grad_r_s ^ grad_g_s};
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hcnt_q  <= 11'd0;
      vcnt_q  <= 11'd0;
      sel_q   <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
      rgb_q   <= 6'b000000;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      sel_q   <= sel_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      rgb_q   <= rgb_d;
    end
  end

  assign Hs    = hs_q;
  assign Vs    = vs_q;
  assign Blank = blank_q;
  assign R     = rgb_q[5:4];
  assign G     = rgb_q[3:2];
  assign B     = rgb_q[1:0];

endmodule

// File: tb/tb_vga_2bit.sv
// Bench for vga_2bit: a full-size instance (line timing, colour bars) and a shrunken instance
// (frame timing, SEL capture, gradient) both checked every cycle against a raster reference model.
module tb_vga_2bit;

  localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48, AVA = 480, AVF = 10, AVS = 2, AVB = 33;
  localparam int AHT = AHA + AHF + AHS + AHB, AVT = AVA + AVF + AVS + AVB;
  localparam int BHA = 80, BHF = 4, BHS = 8, BHB = 4, BVA = 136, BVF = 2, BVS = 2, BVB = 2;
  localparam int BHT = BHA + BHF + BHS + BHB, BVT = BVA + BVF + BVS + BVB;
  localparam int N_CYC = 45000;

`ifdef VGA_BORDER_EN
  localparam logic BORDER = 1'b1;
`else
  localparam logic BORDER = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic sel_a = 1'b0;
  logic sel_b = 1'b0;
  logic hs_a, vs_a, blank_a, hs_b, vs_b, blank_b;
  logic [1:0] r_a, g_a, b_a, r_b, g_b, b_b;

  int n_cmp = 0;
  int n_bad = 0;

  vga_2bit u_dut_a (
    .clock(clock), .reset_n(reset_n), .SEL(sel_a),
    .Hs(hs_a), .Vs(vs_a), .Blank(blank_a), .R(r_a), .G(g_a), .B(b_a)
  );

  vga_2bit #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .SEL(sel_b),
    .Hs(hs_b), .Vs(vs_b), .Blank(blank_b), .R(r_b), .G(g_b), .B(b_b)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {Hs,Vs,Blank,R,G,B} for pixel (x,y) of a raster with the given geometry.
  function automatic logic [8:0] ref_pixel(input int ha, input int hf, input int hs, input int va,
                                           input int vf, input int vs, input int x, input int y,
                                           input logic sel);
    logic hs_e, vs_e, bl_e;
    logic [5:0] rgb;
    logic [31:0] xv, yv, kv;
    xv = x;
    yv = y;
    kv = x / (ha / 8);
    hs_e = !(x >= ha + hf && x < ha + hf + hs);
    vs_e = !(y >= va + vf && y < va + vf + vs);
    bl_e = (x >= ha) || (y >= va);
    if (bl_e)
      rgb = 6'b000000;
    else if (BORDER && (x == 0 || x == ha - 1 || y == 0 || y == va - 1))
      rgb = 6'b111111;
    else if (!sel)
      rgb = {kv[2], kv[2], kv[1], kv[1], kv[0], kv[0]};
    else
      rgb = {xv[7:6], yv[7:6], xv[7:6] ^ yv[7:6]};
    return {hs_e, vs_e, bl_e, rgb};
  endfunction

  initial begin
    int cur_a, cur_b, next_a, next_b, xa, ya, xb, yb;
    int hs_low, blank_hi, hs_fall, blank_fall, vs_low, b_blank, first_vs;
    logic msel_a, msel_b, prev_hs_a, prev_blank_a, prev_vs_b;
    logic [8:0] exp_a, exp_b;
    logic [5:0] rgb_a_s, rgb_b_s, bar_exp;
    next_a = 0; next_b = 0; cur_a = -1; cur_b = -1;
    msel_a = 1'b0; msel_b = 1'b0;
    prev_hs_a = 1'b1; prev_blank_a = 1'b1; prev_vs_b = 1'b1;
    hs_low = 0; blank_hi = 0; hs_fall = -1; blank_fall = -1;
    vs_low = 0; b_blank = 0; first_vs = -1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clock);
      // Reference model: advance on the edge just taken with the inputs that were applied.
      if (!reset_n) begin
        exp_a = 9'h1C0; exp_b = 9'h1C0;
        next_a = 0; next_b = 0; cur_a = -1; cur_b = -1;
        msel_a = 1'b0; msel_b = 1'b0;
      end else begin
        cur_a = next_a; next_a++;
        xa = cur_a % AHT; ya = (cur_a / AHT) % AVT;
        if (xa == 0 && ya == 0) msel_a = sel_a;
        exp_a = ref_pixel(AHA, AHF, AHS, AVA, AVF, AVS, xa, ya, msel_a);
        cur_b = next_b; next_b++;
        xb = cur_b % BHT; yb = (cur_b / BHT) % BVT;
        if (xb == 0 && yb == 0) msel_b = sel_b;
        exp_b = ref_pixel(BHA, BHF, BHS, BVA, BVF, BVS, xb, yb, msel_b);
      end
      rgb_a_s = {r_a, g_a, b_a};
      rgb_b_s = {r_b, g_b, b_b};
      check_eq("a_pixel", {23'd0, hs_a, vs_a, blank_a, rgb_a_s}, {23'd0, exp_a});
      check_eq("b_pixel", {23'd0, hs_b, vs_b, blank_b, rgb_b_s}, {23'd0, exp_b});

      // First pixel after reset release is visible pixel (0,0).
      if (cur_a == 0) begin
        check_eq("a_first_blank", {31'd0, blank_a}, 32'd0);
        check_eq("a_first_rgb", {26'd0, rgb_a_s}, BORDER ? 32'h3F : 32'h00);
      end

      // Colour bars on line 10 of the full-size raster.
      if (cur_a >= 10 * AHT && cur_a < 11 * AHT) begin
        xa = cur_a - 10 * AHT;
        if (xa == 0 || xa == 40 || xa == 79 || xa == 80 || xa == 320 || xa == 639 || xa == 640) begin
          case (xa)
            0:       bar_exp = BORDER ? 6'b111111 : 6'b000000;
            40:      bar_exp = 6'b000000;
            79:      bar_exp = 6'b000000;
            80:      bar_exp = 6'b000011;
            320:     bar_exp = 6'b110000;
            639:     bar_exp = 6'b111111;
            default: bar_exp = 6'b000000;
          endcase
          check_eq($sformatf("a_bar_x%0d", xa), {26'd0, rgb_a_s}, {26'd0, bar_exp});
        end
      end

      // Line timing measured on line 5 of the full-size raster.
      if (cur_a >= 5 * AHT && cur_a < 6 * AHT) begin
        if (cur_a == 5 * AHT) begin
          hs_low = 0; blank_hi = 0; hs_fall = -1; blank_fall = -1;
        end
        if (!hs_a) hs_low++;
        if (blank_a) blank_hi++;
        if (prev_hs_a && !hs_a) hs_fall = cur_a;
        if (prev_blank_a && !blank_a) blank_fall = cur_a;
        if (cur_a == 6 * AHT - 1) begin
          check_eq("a_hs_low_clocks", hs_low, 32'd96);
          check_eq("a_blank_clocks", blank_hi, 32'd160);
          check_eq("a_hs_after_blank", hs_fall - blank_fall, 32'd656);
        end
      end
      prev_hs_a = hs_a;
      prev_blank_a = blank_a;

      // Frame timing over the first frame of the shrunken raster.
      if (cur_b >= 0 && cur_b < BHT * BVT) begin
        if (cur_b == 0) begin
          vs_low = 0; b_blank = 0; first_vs = -1;
        end
        if (!vs_b) vs_low++;
        if (blank_b) b_blank++;
        if (prev_vs_b && !vs_b && first_vs < 0) first_vs = cur_b;
        if (cur_b == BHT * BVT - 1) begin
          check_eq("b_vs_low_clocks", vs_low, BVS * BHT);
          check_eq("b_vs_first_line", first_vs / BHT, BVA + BVF);
          check_eq("b_vs_first_col", first_vs % BHT, 32'd0);
          check_eq("b_blank_clocks", b_blank, BHT * BVT - BHA * BVA);
        end
      end
      prev_vs_b = vs_b;

      // Frame 1 of the shrunken raster is forced to gradient: pixel (64,128).
      if (cur_b == BHT * BVT + 128 * BHT + 64)
        check_eq("b_grad_64_128", {26'd0, rgb_b_s}, 32'h1B);

      // Stimulus for the next edge.
      reset_n = !(cyc < 2 || (cyc >= 30000 && cyc < 30003));
      if (cur_b + 1 >= BHT * BVT - 250 && cur_b + 1 <= BHT * BVT + 50)
        sel_b = 1'b1;
      else if (cur_b + 1 >= 2 * BHT * BVT - 250 && cur_b + 1 <= 2 * BHT * BVT + 50)
        sel_b = 1'b0;
      else
        sel_b = 1'($urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
